// File: rtl/exc_pkg.sv
// exc_pkg: shared types and constants for the precise-exception pipeline.
//   - MIPS excodes, default exception vector
//   - exc_slot_t: per-instruction exception payload carried through ID/EX/MEM
//   - exc_cause_t: causes raised by one stage in the current cycle
//   - merge_causes(): first-cause-wins merge with same-stage priority
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  typedef struct packed {
    logic        valid;
    logic        pend;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
  } exc_slot_t;

  localparam int unsigned SLOT_W = $bits(exc_slot_t);

  typedef struct packed {
    logic        adel_f;  // fetch address error, badvaddr = pc
    logic        ri;
    logic        sys;
    logic        bp;
    logic        ov;
    logic        adel_d;  // data address errors, badvaddr = daddr
    logic        ades;
    logic [31:0] daddr;
    logic        bd;
    logic        eret;
  } exc_cause_t;

  localparam exc_cause_t NO_CAUSE = '0;

  // Fold this stage's causes into a slot; an already pending cause is kept.
  function automatic exc_slot_t merge_causes(exc_slot_t s, exc_cause_t c);
    exc_slot_t r;
    r = s;
    if (s.valid) begin
      if (!s.pend) begin
        r.pend = 1'b1;
        if (c.adel_f) begin
          r.excode   = EXC_ADEL;
          r.badvaddr = s.pc;
        end else if (c.ri) begin
          r.excode = EXC_RI;
        end else if (c.sys) begin
          r.excode = EXC_SYS;
        end else if (c.bp) begin
          r.excode = EXC_BP;
        end else if (c.ov) begin
          r.excode = EXC_OV;
        end else if (c.adel_d) begin
          r.excode   = EXC_ADEL;
          r.badvaddr = c.daddr;
        end else if (c.ades) begin
          r.excode   = EXC_ADES;
          r.badvaddr = c.daddr;
        end else begin
          r.pend = 1'b0;
        end
      end
      r.bd   = s.bd | c.bd;
      // eret only counts on an instruction that is not already excepting
      r.eret = s.eret | (c.eret & ~r.pend);
    end
    return r;
  endfunction

endpackage

// File: rtl/exc_pipe_if.sv
// exc_pipe_if: pipeline/cp0 side signals of the exception pipeline.
//   master: pipeline + cp0 (drives stage causes, enables, cp0 status)
//   slave : exc_pipe (drives commit strobes, flush and redirect)
interface exc_pipe_if;
  logic        id_en, ex_en, mem_en;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_adel;
  logic        id_bd, id_ri, id_sys, id_bp, id_eret;
  logic        ex_ov;
  logic        mem_adel, mem_ades;
  logic [31:0] mem_addr;
  logic        status_ie, status_exl;
  logic [7:0]  status_im, cause_ip;
  logic [31:0] epc;
  logic        exception, eret;
  logic [4:0]  excode;
  logic [31:0] badvaddr, exc_pc;
  logic        is_delay_slot;
  logic        mem_cancel;
  logic        flush;
  logic [31:0] redirect_pc;

  modport master (
    output id_en, ex_en, mem_en, if_valid, if_pc, if_adel,
           id_bd, id_ri, id_sys, id_bp, id_eret, ex_ov,
           mem_adel, mem_ades, mem_addr,
           status_ie, status_exl, status_im, cause_ip, epc,
    input  exception, eret, excode, badvaddr, exc_pc, is_delay_slot,
           mem_cancel, flush, redirect_pc
  );

  modport slave (
    input  id_en, ex_en, mem_en, if_valid, if_pc, if_adel,
           id_bd, id_ri, id_sys, id_bp, id_eret, ex_ov,
           mem_adel, mem_ades, mem_addr,
           status_ie, status_exl, status_im, cause_ip, epc,
    output exception, eret, excode, badvaddr, exc_pc, is_delay_slot,
           mem_cancel, flush, redirect_pc
  );
endinterface

// File: rtl/exc_stage_reg.sv
// exc_stage_reg: one pipeline exception slot.
//   clk, reset : clock, synchronous active-high reset
//   ld, clr    : load d / clear to bubble (clr wins); otherwise hold
//   d          : payload from the previous stage
//   cause      : causes raised by this stage this cycle
//   o          : held payload with this stage's causes merged in
module exc_stage_reg
  import exc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic       clr,
  input  exc_slot_t  d,
  input  exc_cause_t cause,
  output exc_slot_t  o
);

  logic [SLOT_W-1:0] q_r;

  // Slot register: clear beats load, otherwise hold
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q_r <= '0;
    end else if (ld) begin
      q_r <= d;
    end
  end

  assign o = merge_causes(exc_slot_t'(q_r), cause);

endmodule

// File: rtl/exc_pipe.sv
// exc_pipe: precise-exception pipeline for the mipsel32 core.
//   clk, reset : clock, synchronous active-high reset
//   bus        : exc_pipe_if.slave (stage causes, enables, cp0 status in;
//                commit strobes, excode/badvaddr/exc_pc/bd, mem_cancel,
//                registered flush/redirect_pc out)
// Commit strobes are combinational from the MEM slot; flush/redirect_pc are
// registered and valid for the single cycle after the strobe.
// Build option: define EXC_INT_EN to enable interrupt requests from
// status/cause; otherwise interrupts are never taken.
module exc_pipe
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic      clk,
  input  logic      reset,
  exc_pipe_if.slave bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        flush_q, flush_nxt;
  logic [31:0] redir_q, redir_nxt;

  exc_slot_t   if_slot, id_d, id_o, ex_o, mem_o;
  exc_cause_t  if_cause, id_cause, ex_cause, mem_cause;
  logic        int_req, run, commit, exc_c, eret_c, take, ld_ok;

  // Per-stage cause bundles
  always_comb begin
    if_slot          = '0;
    if_slot.valid    = bus.if_valid;
    if_slot.pc       = bus.if_pc;
    if_cause         = NO_CAUSE;
    if_cause.adel_f  = bus.if_adel;
    id_cause         = NO_CAUSE;
    id_cause.ri      = bus.id_ri;
    id_cause.sys     = bus.id_sys;
    id_cause.bp      = bus.id_bp;
    id_cause.bd      = bus.id_bd;
    id_cause.eret    = bus.id_eret;
    ex_cause         = NO_CAUSE;
    ex_cause.ov      = bus.ex_ov;
    mem_cause        = NO_CAUSE;
    mem_cause.adel_d = bus.mem_adel;
    mem_cause.ades   = bus.mem_ades;
    mem_cause.daddr  = bus.mem_addr;
  end

  assign id_d = merge_causes(if_slot, if_cause);

`ifdef EXC_INT_EN
  assign int_req = bus.status_ie & ~bus.status_exl & (|(bus.status_im & bus.cause_ip));
`else
  logic int_unused;
  assign int_unused = ^{bus.status_ie, bus.status_exl, bus.status_im, bus.cause_ip};
  assign int_req    = 1'b0;
`endif

  // Commit resolution at MEM
  assign run    = (state == ST_RUN);
  assign commit = run & mem_o.valid & ~reset;
  assign exc_c  = commit & (int_req | mem_o.pend);
  assign eret_c = commit & ~exc_c & mem_o.eret;
  assign take   = exc_c | eret_c;
  // Slots freeze during FLUSH and on the committing edge (they are cleared)
  assign ld_ok  = run & ~take;

  exc_stage_reg u_id (
    .clk(clk), .reset(reset), .ld(bus.id_en & ld_ok), .clr(take),
    .d(id_d), .cause(id_cause), .o(id_o)
  );

  exc_stage_reg u_ex (
    .clk(clk), .reset(reset), .ld(bus.ex_en & ld_ok), .clr(take),
    .d(id_o), .cause(ex_cause), .o(ex_o)
  );

  exc_stage_reg u_mem (
    .clk(clk), .reset(reset), .ld(bus.mem_en & ld_ok), .clr(take),
    .d(ex_o), .cause(mem_cause), .o(mem_o)
  );

  assign bus.exception     = exc_c;
  assign bus.eret          = eret_c;
  assign bus.mem_cancel    = take;
  assign bus.excode        = !commit ? 5'h00 : (int_req ? EXC_INT : mem_o.excode);
  assign bus.badvaddr      = commit ? mem_o.badvaddr : 32'h0;
  assign bus.exc_pc        = commit ? mem_o.pc : 32'h0;
  assign bus.is_delay_slot = commit & mem_o.bd;
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redir_q;

  // State and registered flush/redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      flush_q <= 1'b0;
      redir_q <= '0;
    end else begin
      state   <= state_nxt;
      flush_q <= flush_nxt;
      redir_q <= redir_nxt;
    end
  end

  // Next state: one FLUSH cycle after every exception/eret commit
  always_comb begin
    state_nxt = state;
    flush_nxt = 1'b0;
    redir_nxt = '0;
    unique case (state)
      ST_RUN: begin
        if (take) begin
          state_nxt = ST_FLUSH;
          flush_nxt = 1'b1;
          redir_nxt = exc_c ? EXC_VECTOR : bus.epc;
        end
      end
      ST_FLUSH: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule

// File: doc/exc_pipe.md
# exc_pipe

Precise-exception pipeline for the mipsel32 core. Collects exception causes raised in IF/ID/EX/MEM and carries them with each instruction through ID, EX and MEM slot registers. Resolves them at commit (MEM), together with pending interrupts, into the single-cycle exception/eret strobes, excode, badvaddr, pc and delay-slot flag that cp0 consumes. Drives the pipeline flush and fetch redirect that follow.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380: redirect target on exception (BEV=1).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_en / ex_en / mem_en  in  1  slot advance: load from the previous stage this cycle
- if_valid, if_pc, if_adel  in  1/32/1  fetched instruction; PC misaligned
- id_bd, id_ri, id_sys, id_bp, id_eret  in  1 each  delay slot; reserved instr; syscall; break; eret
- ex_ov  in  1  arithmetic overflow
- mem_adel, mem_ades, mem_addr  in  1/1/32  load/store misaligned; data address
- status_ie, status_exl  in  1  from cp0
- status_im, cause_ip  in  8  from cp0
- epc  in  32  from cp0, eret target
- exception, eret  out  1  one-cycle commit strobes to cp0
- excode  out  5  to cp0
- badvaddr, exc_pc  out  32  to cp0
- is_delay_slot  out  1  to cp0
- mem_cancel  out  1  suppress MEM store/writeback this cycle
- flush  out  1  registered; clear IF/ID/EX/MEM
- redirect_pc  out  32  valid when flush=1

## Operation
- Slot payload: valid, pend, excode[4:0], badvaddr[31:0], pc[31:0], bd, eret.
- Loading: ID slot takes the IF inputs. EX and MEM slots copy the previous slot. Non-advancing slots hold.
- Once pend=1, later-stage causes are ignored; the first recorded cause wins.
- Same-stage priority: AdEL(fetch, badvaddr=pc) > RI > Sys > Bp > Ov > AdEL/AdES(data, badvaddr=mem_addr).
- Excodes: Int 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C.
- eret: recorded only when no exception is pending.
- int_req = status_ie & ~status_exl & |(status_im & cause_ip).
- Commit, in the RUN state with MEM.valid:
  - exception = int_req | MEM.pend.
  - When int_req=1, excode=Int and the interrupt overrides the recorded cause.
  - Otherwise eret = MEM.eret.
  - exc_pc = MEM.pc; is_delay_slot = MEM.bd; badvaddr = MEM.badvaddr.
- mem_cancel = exception | eret, combinational.
- FSM states RUN and FLUSH:
  - RUN→FLUSH on exception or eret. At that edge: flush<=1, all slot valid<=0, redirect_pc<=EXC_VECTOR (exception) or epc (eret).
  - FLUSH→RUN after exactly one cycle. Slot loads are ignored in FLUSH and slots hold bubbles.
  - No strobes are issued in FLUSH.

## Timing
- Reset: state RUN; all slots invalid; flush=0; redirect_pc=0.
- Reset: exception=eret=mem_cancel=0; excode=0; badvaddr=exc_pc=0; is_delay_slot=0.
- Strobes are combinational from the MEM slot in cycle T. cp0 samples them at the T edge.
- flush and redirect_pc are high/valid for cycle T+1 only.
- Simultaneous exception and eret in MEM: the exception wins; eret=0.
- mem_en=0 with an excepting MEM slot: the strobe is still issued, once. The slot is cleared at that edge.
- Reset mid-flush: returns to RUN with flush=0 on the next edge.

## Configuration
- EXC_INT_EN defined: int_req is computed as above.
- EXC_INT_EN undefined: int_req is tied to 0, status/cause inputs are unused, and excode Int is never produced.

## Structure
- Shared package exc_pkg:
  - excode localparams.
  - Slot payload struct/width constant.
  - EXC_VECTOR default.
- One sub-module, exc_stage_reg: one slot with load, hold, clear, first-cause-wins merge and priority encoding. Instantiated 3×.

## Test plan
- ID ri=1, pc=0x80001000, advancing each cycle → two cycles later: exception=1, excode=0x0A, exc_pc=0x80001000. Next cycle: flush=1, redirect_pc=0xBFC00380.
- IF adel, pc=0x80000002, plus ex_ov on the same instruction → excode=0x04, badvaddr=0x80000002.
- MEM ades, mem_addr=0x1003, bd=1 → excode=0x05, badvaddr=0x1003, is_delay_slot=1, mem_cancel=1.
- eret in MEM with epc=0x80002000 → eret=1, exception=0. Next cycle: redirect_pc=0x80002000.
- EXC_INT_EN: ie=1, exl=0, im=0x80, ip=0x80 with Sys in MEM → excode=0x00. With exl=1 instead → excode=0x08.
- Reset asserted in FLUSH → flush=0 and all strobes 0 on the next cycle.
